// File: rtl/jump_control_pkg.sv
// jump_control_pkg: shared opcode constants and the branch decision struct for KGP-RISC branch resolution
package jump_control_pkg;
  localparam int OPW = 6;
  localparam logic [OPW-1:0] OP_B    = 6'b101000;
  localparam logic [OPW-1:0] OP_BR   = 6'b100000;
  localparam logic [OPW-1:0] OP_BL   = 6'b101011;
  localparam logic [OPW-1:0] OP_BLTZ = 6'b110000;
  localparam logic [OPW-1:0] OP_BZ   = 6'b110001;
  localparam logic [OPW-1:0] OP_BNZ  = 6'b110010;
  localparam logic [OPW-1:0] OP_BCY  = 6'b101001;
  localparam logic [OPW-1:0] OP_BNCY = 6'b101010;
  typedef struct packed {
    logic taken;
    logic is_branch;
    logic link_en;
    logic reg_target;
  } jump_dec_t;
endpackage

// File: rtl/branch_cond_decode.sv
// branch_cond_decode: combinational opcode + ALU flags -> branch decision, shared with the hazard unit
module branch_cond_decode
  import jump_control_pkg::*;
(
  input  logic [OPW-1:0] op_code_i,
  input  logic           flag_zero_i,
  input  logic           flag_sign_i,
  input  logic           flag_carry_i,
  output jump_dec_t      dec_o
);
  // Unknown or undefined opcodes fall to the default and decode as non-branch
  always_comb begin
    dec_o = '0;
    case (op_code_i)
      OP_B:    dec_o = 4'b1100;
      OP_BR:   dec_o = 4'b1101;
      OP_BL:   dec_o = 4'b1110;
      OP_BLTZ: dec_o = {flag_sign_i, 3'b100};
      OP_BZ:   dec_o = {flag_zero_i, 3'b100};
      OP_BNZ:  dec_o = {~flag_zero_i, 3'b100};
      OP_BCY:  dec_o = {flag_carry_i, 3'b100};
      OP_BNCY: dec_o = {~flag_carry_i, 3'b100};
      default: dec_o = '0;
    endcase
  end
endmodule

// File: rtl/jump_control.sv
// jump_control: registered branch resolution; optional taken-branch counter under JUMP_CONTROL_STATS_EN
module jump_control
  import jump_control_pkg::*;
`ifdef JUMP_CONTROL_STATS_EN
  #(parameter int CNTW = 16)
`endif
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           hold,
  input  logic [OPW-1:0] op_code,
  input  logic           flag_zero,
  input  logic           flag_sign,
  input  logic           flag_carry,
  output logic           flag_output,
  output logic           is_branch,
  output logic           link_en,
  output logic           reg_target
`ifdef JUMP_CONTROL_STATS_EN
  , output logic [CNTW-1:0] taken_count
`endif
);
  jump_dec_t dec, out_d, out_q;

  branch_cond_decode u_dec (
    .op_code_i   (op_code),
    .flag_zero_i (flag_zero),
    .flag_sign_i (flag_sign),
    .flag_carry_i(flag_carry),
    .dec_o       (dec)
  );

  // Hold freezes the decision register; otherwise capture this cycle's decode
  always_comb out_d = hold ? out_q : dec;

  // Decision register, cleared asynchronously so a pending decision is dropped on reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;

  assign flag_output = out_q.taken;
  assign is_branch   = out_q.is_branch;
  assign link_en     = out_q.link_en;
  assign reg_target  = out_q.reg_target;

`ifdef JUMP_CONTROL_STATS_EN
  logic [CNTW-1:0] count_d, count_q;

  // Count taken decisions as they are captured; wraps naturally at all-ones
  always_comb count_d = (!hold && dec.taken) ? count_q + 1'b1 : count_q;

  // Counter register shares the decision register's reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;

  assign taken_count = count_q;
`endif
endmodule

// File: tb/tb_jump_control.sv
// tb_jump_control: randomized + directed self-checking bench for jump_control against a spec-level model
module tb_jump_control;
  logic       clk = 1'b0;
  logic       rst_n, hold, flag_zero, flag_sign, flag_carry;
  logic [5:0] op_code;
  logic       flag_output, is_branch, link_en, reg_target;
`ifdef JUMP_CONTROL_STATS_EN
  logic [15:0] taken_count;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Expected registered outputs {taken, is_branch, link_en, reg_target} and counter
  logic [3:0]  exp_q = '0;
  logic [15:0] exp_cnt = '0;

  always #5 clk = ~clk;

  jump_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold       (hold),
    .op_code    (op_code),
    .flag_zero  (flag_zero),
    .flag_sign  (flag_sign),
    .flag_carry (flag_carry),
    .flag_output(flag_output),
    .is_branch  (is_branch),
    .link_en    (link_en),
    .reg_target (reg_target)
`ifdef JUMP_CONTROL_STATS_EN
    , .taken_count(taken_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Spec-level decision: which opcodes branch, and under which flag
  function automatic logic [3:0] ref_dec(input logic [5:0] op, input logic z, input logic s, input logic c);
    logic t, br, lk, rg;
    br = 1'b1; lk = 1'b0; rg = 1'b0;
    if      (op == 6'b101000) t = 1'b1;
    else if (op == 6'b100000) begin t = 1'b1; rg = 1'b1; end
    else if (op == 6'b101011) begin t = 1'b1; lk = 1'b1; end
    else if (op == 6'b110000) t = s;
    else if (op == 6'b110001) t = z;
    else if (op == 6'b110010) t = !z;
    else if (op == 6'b101001) t = c;
    else if (op == 6'b101010) t = !c;
    else begin t = 1'b0; br = 1'b0; end
    return {t, br, lk, rg};
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, ".flag"}, 32'(flag_output), 32'(exp_q[3]));
    chk({tag, ".isbr"}, 32'(is_branch),   32'(exp_q[2]));
    chk({tag, ".link"}, 32'(link_en),     32'(exp_q[1]));
    chk({tag, ".rtgt"}, 32'(reg_target),  32'(exp_q[0]));
`ifdef JUMP_CONTROL_STATS_EN
    chk({tag, ".cnt"},  32'(taken_count), 32'(exp_cnt));
`endif
  endtask

  task automatic step(input string tag, input logic [5:0] op, input logic z, input logic s,
                      input logic c, input logic h);
    logic [3:0] d;
    op_code = op; flag_zero = z; flag_sign = s; flag_carry = c; hold = h;
    d = ref_dec(op, z, s, c);
    @(posedge clk);
    if (!h) begin
      exp_q = d;
      exp_cnt = exp_cnt + 16'(d[3]);
    end
    #1 check_outs(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    exp_q = '0; exp_cnt = '0;
    check_outs("rst_async");
    @(posedge clk); #1;
    check_outs("rst_held");
    rst_n = 1'b1;
  endtask

  logic [5:0] ops [8] = '{6'b101000, 6'b100000, 6'b101011, 6'b110000,
                          6'b110001, 6'b110010, 6'b101001, 6'b101010};

  initial begin
    rst_n = 1'b0; hold = 1'b0; op_code = 6'b101000;
    flag_zero = 1'b0; flag_sign = 1'b0; flag_carry = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_outs("reset");
    rst_n = 1'b1;
    step("rel_b", 6'b101000, 0, 0, 0, 0);
    chk("rel_b.flag1", 32'(flag_output), 32'd1);
    step("uncond_br", 6'b100000, 0, 0, 0, 0);
    step("uncond_bl", 6'b101011, 0, 0, 0, 0);
    step("bltz_1", 6'b110000, 0, 1, 0, 0);
    step("bltz_0", 6'b110000, 1, 0, 1, 0);
    step("bz_1",   6'b110001, 1, 0, 0, 0);
    step("bz_0",   6'b110001, 0, 1, 1, 0);
    step("bnz_1",  6'b110010, 0, 0, 0, 0);
    step("bnz_0",  6'b110010, 1, 1, 1, 0);
    step("bcy_1",  6'b101001, 0, 0, 1, 0);
    step("bcy_0",  6'b101001, 1, 1, 0, 0);
    step("bncy_1", 6'b101010, 0, 0, 0, 0);
    step("bncy_0", 6'b101010, 1, 1, 1, 0);
    step("nb_000", 6'b000000, 1, 1, 1, 0);
    step("nb_111", 6'b111111, 1, 1, 1, 0);
    do_reset();
    step("hold_latch", 6'b101000, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("hold", 6'b000000, 0, 0, 0, 1);
    chk("hold.flag_kept", 32'(flag_output), 32'd1);
`ifdef JUMP_CONTROL_STATS_EN
    chk("hold.cnt_one", 32'(taken_count), 32'd1);
`endif
    step("hold_rel", 6'b000000, 0, 0, 0, 0);
    op_code = 6'b101000; hold = 1'b0;
    @(posedge clk); exp_q = 4'b1100; exp_cnt = exp_cnt + 16'd1;
    #3 do_reset();
    step("post_rst", 6'b110001, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      step("rand", op, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 4) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
